// File: rtl/irq_injector_pkg.sv
// irq_injector_pkg: shared FSM states, trigger-entry record and default sizes for the IRQ injector
package irq_injector_pkg;
  localparam int N_ENTRIES_D = 32;
  localparam int N_LINES_D = 6;
  localparam int ADDR_W_D = 32;
  localparam int DLY_W_D = 4;
  localparam int LEN_W_D = 4;
  localparam int IDX_W_D = $clog2(N_ENTRIES_D);
  localparam int LINE_W_D = $clog2(N_LINES_D);
  typedef enum logic [1:0] {IDLE, WAIT, ASSERT} state_t;
  typedef struct packed {
    logic [ADDR_W_D-1:0] addr;
    logic [DLY_W_D-1:0] dly;
    logic [LEN_W_D-1:0] len;
    logic [LINE_W_D-1:0] line;
  } entry_t;
endpackage

// File: rtl/irq_injector_if.sv
// irq_injector_if: trigger-table configuration write port
interface irq_injector_if import irq_injector_pkg::*; #(
  parameter int N_ENTRIES = N_ENTRIES_D,
  parameter int N_LINES = N_LINES_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DLY_W = DLY_W_D,
  parameter int LEN_W = LEN_W_D
);
  logic we;
  logic [$clog2(N_ENTRIES)-1:0] idx;
  logic [ADDR_W-1:0] addr;
  logic [DLY_W-1:0] dly;
  logic [LEN_W-1:0] len;
  logic [$clog2(N_LINES)-1:0] line;
  modport master (output we, idx, addr, dly, len, line);
  modport slave (input we, idx, addr, dly, len, line);
endinterface

// File: rtl/irq_inj_match.sv
// irq_inj_match: lowest-index armed entry whose address equals the monitored address
module irq_inj_match import irq_injector_pkg::*; #(
  parameter int N = N_ENTRIES_D,
  parameter int W = ADDR_W_D
) (
  input logic [N-1:0] armed,
  input logic [N-1:0][W-1:0] addrs,
  input logic [W-1:0] addr,
  output logic hit,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (armed[i] && addrs[i] == addr) begin
        hit = 1'b1;
        idx = IW'(i);
      end
  end
endmodule

// File: rtl/irq_injector.sv
// irq_injector: fires a delayed, timed interrupt pulse when the PC hits an armed trigger address
// IRQ_INJ_REARM_EN adds a rearm input that re-arms every entry ever written.
module irq_injector import irq_injector_pkg::*; #(
  parameter int N_ENTRIES = N_ENTRIES_D,
  parameter int N_LINES = N_LINES_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DLY_W = DLY_W_D,
  parameter int LEN_W = LEN_W_D
) (
  input logic clk,
  input logic reset,
`ifdef IRQ_INJ_REARM_EN
  input logic rearm,
`endif
  input logic [ADDR_W-1:0] addr,
  irq_injector_if.slave cfg,
  output logic [N_LINES-1:0] irq,
  output logic busy,
  output logic [7:0] fired_cnt
);
  localparam int IW = $clog2(N_ENTRIES);
  localparam int LW = $clog2(N_LINES);
  localparam int CW = DLY_W > LEN_W ? DLY_W : LEN_W;
  entry_t tbl [N_ENTRIES];
  logic [N_ENTRIES-1:0][ADDR_W-1:0] tbl_addr;
  logic [N_ENTRIES-1:0] armed, armed_n, rearm_set;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [LW-1:0] line_q, line_n;
  logic [N_LINES-1:0] irq_n;
  logic [7:0] fired_n;
  logic hit, fire;
  logic [IW-1:0] hit_idx;
`ifdef IRQ_INJ_REARM_EN
  logic [N_ENTRIES-1:0] written;
  logic pend;
  assign rearm_set = state == IDLE && (rearm || pend) ? written : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      written <= '0;
      pend <= 1'b0;
    end else begin
      if (cfg.we) written[cfg.idx] <= 1'b1;
      pend <= state != IDLE && (rearm || pend);
    end
`else
  assign rearm_set = '0;
`endif
  always_ff @(posedge clk)
    if (cfg.we) tbl[cfg.idx] <= '{addr: cfg.addr, dly: cfg.dly, len: cfg.len, line: cfg.line};
  always_comb
    for (int i = 0; i < N_ENTRIES; i++) tbl_addr[i] = tbl[i].addr;
  irq_inj_match #(.N(N_ENTRIES), .W(ADDR_W)) u_match (
    .armed(armed),
    .addrs(tbl_addr),
    .addr(addr),
    .hit(hit),
    .idx(hit_idx)
  );
  assign busy = state != IDLE;
  // cnt counts down the remaining WAIT cycles, then the remaining ASSERT cycles
  always_comb begin
    fire = state == IDLE && hit && !(cfg.we && cfg.idx == hit_idx);
    state_n = state;
    cnt_n = cnt;
    len_n = len_q;
    line_n = line_q;
    irq_n = irq;
    fired_n = fired_cnt;
    armed_n = armed | rearm_set;
    if (fire) begin
      armed_n[hit_idx] = 1'b0;
      state_n = WAIT;
      cnt_n = CW'(tbl[hit_idx].dly - DLY_W'(tbl[hit_idx].dly != '0));
      len_n = tbl[hit_idx].len;
      line_n = tbl[hit_idx].line;
    end else if (state != IDLE && cnt != '0) cnt_n = cnt - 1'b1;
    else if (state == WAIT) begin
      state_n = ASSERT;
      cnt_n = CW'(len_q);
      irq_n = N_LINES'(1) << line_q;
    end else if (state == ASSERT) begin
      state_n = IDLE;
      irq_n = '0;
      fired_n = fired_cnt + 8'(fired_cnt != 8'hff);
    end
    if (cfg.we) armed_n[cfg.idx] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      len_q <= '0;
      line_q <= '0;
      irq <= '0;
      fired_cnt <= '0;
      armed <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      len_q <= len_n;
      line_q <= line_n;
      irq <= irq_n;
      fired_cnt <= fired_n;
      armed <= armed_n;
    end
endmodule

// File: tb/tb_irq_injector.sv
// tb_irq_injector: randomized scoreboard bench for irq_injector against an event-level model
module tb_irq_injector;
  import irq_injector_pkg::*;
  localparam int NE = 32, NL = 6, AW = 32, DW = 4, LNW = 4, IW = 5, LW = 3;
  localparam logic [AW-1:0] NOADDR = 32'hffff_fff0;
`ifdef IRQ_INJ_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif
  typedef struct {int t; int d; int len; int line; int cnt;} exp_t;
  logic clk = 1'b0, reset = 1'b0, rearm = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [NL-1:0] irq;
  logic busy;
  logic [7:0] fired_cnt;
  irq_injector_if #(.N_ENTRIES(NE), .N_LINES(NL), .ADDR_W(AW), .DLY_W(DW), .LEN_W(LNW)) cfg ();
  irq_injector dut (
    .clk(clk),
    .reset(reset),
`ifdef IRQ_INJ_REARM_EN
    .rearm(rearm),
`endif
    .addr(addr),
    .cfg(cfg),
    .irq(irq),
    .busy(busy),
    .fired_cnt(fired_cnt)
  );
  always #5 clk = ~clk;
  int edges = 0;
  always @(posedge clk) edges <= edges + 1;
  int checks = 0, failures = 0;
  exp_t q[$];
  logic [AW-1:0] m_addr [NE];
  int m_dly [NE], m_len [NE], m_line [NE];
  bit m_armed [NE], m_written [NE];
  bit m_pend = 0;
  int m_fired = 0, end_edge = -1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // event-level model: evaluates what the next rising edge does with the inputs now applied
  task automatic model_edge();
    int k = edges + 1;
    int hit = -1;
    bit idle = k > end_edge;
    if (idle)
      for (int i = 0; i < NE && hit < 0; i++) if (m_armed[i] && m_addr[i] == addr) hit = i;
    if (hit >= 0 && cfg.we && int'(cfg.idx) == hit) hit = -1;
    if (idle && (rearm || m_pend)) begin
      foreach (m_armed[i]) m_armed[i] |= m_written[i];
      m_pend = 0;
    end else if (!idle && rearm) m_pend = 1;
    if (hit >= 0) begin
      int d = m_dly[hit] == 0 ? 1 : m_dly[hit];
      m_armed[hit] = 0;
      end_edge = k + d + m_len[hit] + 1;
      m_fired = m_fired < 255 ? m_fired + 1 : 255;
      q.push_back('{k, d, m_len[hit], m_line[hit], m_fired});
    end
    if (cfg.we) begin
      m_addr[cfg.idx] = cfg.addr;
      m_dly[cfg.idx] = int'(cfg.dly);
      m_len[cfg.idx] = int'(cfg.len);
      m_line[cfg.idx] = int'(cfg.line);
      m_armed[cfg.idx] = 1;
      m_written[cfg.idx] = 1;
    end
  endtask
  task automatic model_reset();
    q.delete();
    foreach (m_armed[i]) begin
      m_armed[i] = 0;
      m_written[i] = 0;
    end
    m_pend = 0;
    m_fired = 0;
    end_edge = -1;
  endtask
  task automatic cyc(input logic [AW-1:0] a, input bit we = 0, input int idx = 0,
                     input logic [AW-1:0] ca = '0, input int dly = 0, input int len = 0,
                     input int line = 0, input bit rr = 0);
    addr = a;
    cfg.we = we;
    cfg.idx = IW'(idx);
    cfg.addr = ca;
    cfg.dly = DW'(dly);
    cfg.len = LNW'(len);
    cfg.line = LW'(line);
    rearm = rr & REARM;
    model_edge();
    @(negedge clk);
  endtask
  task automatic wr(input int idx, input logic [AW-1:0] a, input int dly, input int len, input int line);
    cyc(NOADDR, 1, idx, a, dly, len, line);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(NOADDR);
  endtask
  task automatic drain();
    for (int i = 0; i < 64 && edges <= end_edge; i++) cyc(NOADDR);
    idle(2);
  endtask
  bit trk = 0;
  int t_s, t_r, hi;
  logic [NL-1:0] v;
  exp_t e;
  initial forever begin
    @(negedge clk);
    if (!reset) trk = 0;
    else begin
      if (busy && !trk) begin
        trk = 1;
        t_s = edges;
        t_r = -1;
        hi = 0;
        v = '0;
      end
      if (trk && busy && irq != '0) begin
        if (t_r < 0) t_r = edges;
        hi++;
        v = irq;
      end
      if (trk && !busy) begin
        trk = 0;
        if (q.size() == 0) chk("unexpected_event", 1, 0);
        else begin
          e = q.pop_front();
          chk("start", t_s, e.t);
          chk("rise", t_r, e.line < NL ? e.t + e.d : -1);
          chk("width", hi, e.line < NL ? e.len + 1 : 0);
          chk("line", v, e.line < NL ? 1 << e.line : 0);
          chk("end", edges, e.t + e.d + e.len + 1);
          chk("fired_cnt", fired_cnt, e.cnt);
          chk("irq_idle", irq, 0);
        end
      end
    end
  end
  initial begin
    logic [AW-1:0] pool [8];
    foreach (pool[i]) pool[i] = 32'h4000 + 32'(i * 4);
    cfg.we = 0;
    cfg.idx = '0;
    cfg.addr = '0;
    cfg.dly = '0;
    cfg.len = '0;
    cfg.line = '0;
    @(negedge clk);
    chk("rst_irq0", irq, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_cnt0", fired_cnt, 0);
    @(negedge clk);
    reset = 1;
    wr(0, 32'h30b0, 1, 5, 0);
    cyc(32'h30b0);
    drain();
    chk("first_fire_cnt", fired_cnt, 1);
    wr(3, 32'h3230, 2, 0, 2);
    cyc(32'h3230);
    drain();
    wr(1, 32'h3308, 3, 1, 1);
    wr(4, 32'h3308, 0, 2, 3);
    cyc(32'h3308);
    drain();
    cyc(32'h3308);
    drain();
    cyc(32'h3308);
    idle(3);
    chk("third_hit_busy", busy, 0);
    wr(5, 32'h3340, 1, 0, 4);
    wr(6, 32'h3400, 1, 6, 5);
    cyc(32'h3400);
    idle(3);
    cyc(32'h3340);
    drain();
    cyc(32'h3340);
    drain();
    wr(7, 32'h3500, 0, 0, 1);
    cyc(32'h3500, 1, 7, 32'h3600, 3, 2, 3);
    chk("same_cycle_write_busy", busy, 0);
    cyc(32'h3500);
    cyc(32'h3600);
    drain();
    wr(8, 32'h3700, 2, 3, 7);
    cyc(32'h3700);
    drain();
    wr(9, 32'h3800, 4, 4, 1);
    cyc(32'h3800);
    cyc(NOADDR, 1, 9, 32'h3810, 0, 1, 0);
    drain();
    cyc(32'h3810);
    drain();
    wr(11, 32'h3a00, 0, 0, 0);
    wr(10, 32'h3900, 1, 10, 2);
    cyc(32'h3900);
    idle(4);
    chk("pre_reset_irq", irq, 4);
    #1 reset = 0;
    #1;
    chk("async_rst_irq", irq, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cnt", fired_cnt, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    cyc(32'h3a00);
    idle(3);
    chk("post_reset_disarmed", busy, 0);
    wr(0, 32'h30b0, 1, 5, 0);
    cyc(32'h30b0);
    drain();
    if (REARM) begin
      cyc(NOADDR, 0, 0, '0, 0, 0, 0, 1);
      cyc(32'h30b0);
      drain();
      chk("rearm_cnt", fired_cnt, 2);
    end
    for (int n = 0; n < 2500; n++)
      cyc($urandom_range(0, 99) < 40 ? pool[$urandom_range(0, 7)] : NOADDR,
          $urandom_range(0, 5) == 0, 16 + $urandom_range(0, 15), pool[$urandom_range(0, 7)],
          $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7),
          $urandom_range(0, 30) == 0);
    drain();
    for (int n = 0; n < 260; n++) begin
      wr(12, 32'h3b00, 0, 0, 0);
      cyc(32'h3b00);
      drain();
    end
    chk("fired_saturated", fired_cnt, 255);
    chk("queue_empty", q.size(), 0);
    chk("final_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
